com_rxf_lane: RTL and testbench

Parametrised successor to the fixed 4-bit receive framer: it deserialises a `LANE_W`-bit pin bus qualified by a `fire` strobe into bytes. It also counts received bytes, and can optionally abort a stalled partial byte. It sits on the fast link clock between the pin-side transmit framer output and `com_rx`, whose `com_rxd` it drives through `dout`.

---
 rtl/com_rxf_lane.sv | 150 +++++++++++++++
 tb/tb_com_rxf_lane.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/com_rxf_lane.sv
// Receive lane framer: deserialises LANE_W-bit beats (qualified by fire) into MSB-first bytes.
// Optional partial-byte timeout abort is built when COM_RXF_LANE_TIMEOUT_EN is defined.
module com_rxf_lane #(
    parameter int LANE_W  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire,
    input  logic [LANE_W-1:0] din,
    input  logic              clr,
    output logic [7:0]        dout,
    output logic              dout_vld,
    output logic              busy,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              err_trunc
);
    localparam int BEATS = 8 / LANE_W;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_reg, state_next;
    logic [BC_W-1:0]   beat_reg, beat_next;
    logic [7:0]        dout_reg, dout_next;
    logic              vld_reg, vld_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [7:0]        assembled;
    logic              take;
    logic              last_beat;

    assign take = fire & ~clr;

    // Partial beats live in a register just wide enough for BEATS-1 beats;
    // the incoming beat is concatenated below them to form the byte.
    if (BEATS == 1) begin : g_direct
        assign assembled = din;
    end else begin : g_shift
        logic [7-LANE_W:0] shreg_reg;

        assign assembled = {shreg_reg, din};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shreg_reg <= '0;
            end else if (take) begin
                shreg_reg <= assembled[7-LANE_W:0];
            end
        end
    end

    assign last_beat = (state_reg == IDLE) ? (BEATS == 1) : (beat_reg == LAST_BEAT);

`ifdef COM_RXF_LANE_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    logic [GAP_W-1:0] gap_reg, gap_next;
    logic             trunc_reg, trunc_next;
`endif

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        dout_next  = dout_reg;
        vld_next   = 1'b0;
        cnt_next   = cnt_reg;
`ifdef COM_RXF_LANE_TIMEOUT_EN
        gap_next   = gap_reg;
        trunc_next = 1'b0;
`endif
        if (clr) begin
            state_next = IDLE;
            beat_next  = '0;
            cnt_next   = '0;
`ifdef COM_RXF_LANE_TIMEOUT_EN
            gap_next   = '0;
`endif
        end else if (fire) begin
`ifdef COM_RXF_LANE_TIMEOUT_EN
            gap_next = '0;
`endif
            if (last_beat) begin
                state_next = IDLE;
                beat_next  = '0;
                dout_next  = assembled;
                vld_next   = 1'b1;
                if (!(&cnt_reg)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end else begin
                state_next = SHIFT;
                beat_next  = beat_reg + BC_W'(1);
            end
        end else begin
`ifdef COM_RXF_LANE_TIMEOUT_EN
            // Idle cycle: only a pending partial byte ages toward the abort.
            if (state_reg == SHIFT) begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                    beat_next  = '0;
                    gap_next   = '0;
                    trunc_next = 1'b1;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end else begin
                gap_next = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            dout_reg  <= 8'h00;
            vld_reg   <= 1'b0;
            cnt_reg   <= '0;
`ifdef COM_RXF_LANE_TIMEOUT_EN
            gap_reg   <= '0;
            trunc_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            dout_reg  <= dout_next;
            vld_reg   <= vld_next;
            cnt_reg   <= cnt_next;
`ifdef COM_RXF_LANE_TIMEOUT_EN
            gap_reg   <= gap_next;
            trunc_reg <= trunc_next;
`endif
        end
    end

    assign dout     = dout_reg;
    assign dout_vld = vld_reg;
    assign busy     = (state_reg == SHIFT);
    assign byte_cnt = cnt_reg;
`ifdef COM_RXF_LANE_TIMEOUT_EN
    assign err_trunc = trunc_reg;
`else
    assign err_trunc = 1'b0;
`endif

endmodule

// File: tb/tb_com_rxf_lane.sv
// Directed bench for com_rxf_lane: three instances (LANE_W 4, 2 and 8 with a 4-bit counter).
// Timeout scenarios follow COM_RXF_LANE_TIMEOUT_EN; without it a partial byte must be held.
module tb_com_rxf_lane;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       fire4 = 1'b0, clr4 = 1'b0;
    logic [3:0] din4 = '0;
    logic [7:0] dout4;
    logic       vld4, busy4, err4;
    logic [11:0] cnt4;

    logic       fire2 = 1'b0, clr2 = 1'b0;
    logic [1:0] din2 = '0;
    logic [7:0] dout2;
    logic       vld2, busy2, err2;
    logic [11:0] cnt2;

    logic       fire8 = 1'b0, clr8 = 1'b0;
    logic [7:0] din8 = '0;
    logic [7:0] dout8;
    logic       vld8, busy8, err8;
    logic [3:0] cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    com_rxf_lane #(.LANE_W(4), .TIMEOUT(16), .CNT_W(12)) u4 (
        .clk(clk), .rst(rst), .fire(fire4), .din(din4), .clr(clr4),
        .dout(dout4), .dout_vld(vld4), .busy(busy4), .byte_cnt(cnt4), .err_trunc(err4));

    com_rxf_lane #(.LANE_W(2), .TIMEOUT(16), .CNT_W(12)) u2 (
        .clk(clk), .rst(rst), .fire(fire2), .din(din2), .clr(clr2),
        .dout(dout2), .dout_vld(vld2), .busy(busy2), .byte_cnt(cnt2), .err_trunc(err2));

    com_rxf_lane #(.LANE_W(8), .TIMEOUT(16), .CNT_W(4)) u8 (
        .clk(clk), .rst(rst), .fire(fire8), .din(din8), .clr(clr8),
        .dout(dout8), .dout_vld(vld8), .busy(busy8), .byte_cnt(cnt8), .err_trunc(err8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if (dout4 !== 8'h00) begin errors++; $display("FAIL rst_dout got=%0h exp=00", dout4); end checks++;
        if (vld4 !== 1'b0) begin errors++; $display("FAIL rst_vld got=%0b exp=0", vld4); end checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy4); end checks++;
        if (cnt4 !== 12'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt4); end checks++;
        if (err4 !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err4); end checks++;
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_lane4_basic();
        fire4 = 1'b1; din4 = 4'h4;
        tick();
        if (busy4 !== 1'b1) begin errors++; $display("FAIL l4_busy_mid got=%0b exp=1", busy4); end checks++;
        if (vld4 !== 1'b0) begin errors++; $display("FAIL l4_vld_mid got=%0b exp=0", vld4); end checks++;
        din4 = 4'hF;
        tick();
        fire4 = 1'b0;
        if (dout4 !== 8'h4F) begin errors++; $display("FAIL l4_dout got=%0h exp=4f", dout4); end checks++;
        if (vld4 !== 1'b1) begin errors++; $display("FAIL l4_vld got=%0b exp=1", vld4); end checks++;
        if (cnt4 !== 12'd1) begin errors++; $display("FAIL l4_cnt got=%0d exp=1", cnt4); end checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL l4_busy_end got=%0b exp=0", busy4); end checks++;
        tick();
        if (vld4 !== 1'b0) begin errors++; $display("FAIL l4_vld_drop got=%0b exp=0", vld4); end checks++;
        if (dout4 !== 8'h4F) begin errors++; $display("FAIL l4_dout_hold got=%0h exp=4f", dout4); end checks++;
        $display("lane4 byte dout=%0h cnt=%0d", dout4, cnt4);
    endtask

    task automatic test_back_to_back();
        logic [3:0] beats [4];
        logic [3:0] exp_vld;
        beats = '{4'h1, 4'h2, 4'h3, 4'h4};
        exp_vld = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            fire4 = 1'b1; din4 = beats[i];
            tick();
            if (vld4 !== exp_vld[i]) begin errors++; $display("FAIL b2b_vld%0d got=%0b exp=%0b", i, vld4, exp_vld[i]); end checks++;
            if (i == 1 && dout4 !== 8'h12) begin errors++; $display("FAIL b2b_dout1 got=%0h exp=12", dout4); end checks++;
            if (i == 3 && dout4 !== 8'h34) begin errors++; $display("FAIL b2b_dout2 got=%0h exp=34", dout4); end checks++;
        end
        fire4 = 1'b0;
        if (cnt4 !== 12'd3) begin errors++; $display("FAIL b2b_cnt got=%0d exp=3", cnt4); end checks++;
        tick();
        $display("lane4 back-to-back dout=%0h cnt=%0d", dout4, cnt4);
    endtask

    task automatic test_lane2_gaps();
        logic [1:0] beats [4];
        int pulses;
        beats = '{2'd1, 2'd2, 2'd3, 2'd0};
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            fire2 = 1'b1; din2 = beats[i];
            tick();
            fire2 = 1'b0;
            if (i < 3) begin
                pulses += int'(vld2);
                for (int j = 0; j < 3; j++) begin
                    tick();
                    pulses += int'(vld2);
                    if (busy2 !== 1'b1) begin errors++; $display("FAIL l2_busy_gap%0d got=%0b exp=1", i, busy2); end checks++;
                end
            end else begin
                if (vld2 !== 1'b1) begin errors++; $display("FAIL l2_vld got=%0b exp=1", vld2); end checks++;
                if (dout2 !== 8'h6C) begin errors++; $display("FAIL l2_dout got=%0h exp=6c", dout2); end checks++;
            end
        end
        if (pulses !== 0) begin errors++; $display("FAIL l2_early_vld got=%0d exp=0", pulses); end checks++;
        tick();
        if (vld2 !== 1'b0) begin errors++; $display("FAIL l2_vld_drop got=%0b exp=0", vld2); end checks++;
        $display("lane2 gapped byte dout=%0h", dout2);
    endtask

    task automatic test_timeout();
        fire4 = 1'b1; din4 = 4'hA;
        tick();
        fire4 = 1'b0;
`ifdef COM_RXF_LANE_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            tick();
            if (err4 !== (k == 15)) begin errors++; $display("FAIL to_err%0d got=%0b exp=%0b", k, err4, (k == 15)); end checks++;
            if (busy4 !== (k < 15)) begin errors++; $display("FAIL to_busy%0d got=%0b exp=%0b", k, busy4, (k < 15)); end checks++;
        end
        if (dout4 !== 8'h34) begin errors++; $display("FAIL to_dout_hold got=%0h exp=34", dout4); end checks++;
        tick();
        if (err4 !== 1'b0) begin errors++; $display("FAIL to_err_drop got=%0b exp=0", err4); end checks++;
        fire4 = 1'b1; din4 = 4'h1;
        tick();
        din4 = 4'h2;
        tick();
        fire4 = 1'b0;
        if (dout4 !== 8'h12) begin errors++; $display("FAIL to_realign got=%0h exp=12", dout4); end checks++;
        fire4 = 1'b1; din4 = 4'hA;
        tick();
        fire4 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (err4 !== 1'b0) begin errors++; $display("FAIL to_near_err%0d got=%0b exp=0", k, err4); end checks++;
        end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            if (err4 !== 1'b0) begin errors++; $display("FAIL hold_err%0d got=%0b exp=0", k, err4); end checks++;
            if (busy4 !== 1'b1) begin errors++; $display("FAIL hold_busy%0d got=%0b exp=1", k, busy4); end checks++;
        end
`endif
        fire4 = 1'b1; din4 = 4'h5;
        tick();
        fire4 = 1'b0;
        if (dout4 !== 8'hA5) begin errors++; $display("FAIL to_late_dout got=%0h exp=a5", dout4); end checks++;
        if (err4 !== 1'b0) begin errors++; $display("FAIL to_late_err got=%0b exp=0", err4); end checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL to_late_busy got=%0b exp=0", busy4); end checks++;
        tick();
        $display("lane4 gap scenario dout=%0h", dout4);
    endtask

    task automatic test_saturate();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            fire8 = 1'b1; din8 = 8'(i + 1);
            tick();
            pulses += int'(vld8);
        end
        fire8 = 1'b0;
        if (pulses !== 20) begin errors++; $display("FAIL sat_pulses got=%0d exp=20", pulses); end checks++;
        if (cnt8 !== 4'd15) begin errors++; $display("FAIL sat_cnt got=%0d exp=15", cnt8); end checks++;
        if (dout8 !== 8'h14) begin errors++; $display("FAIL sat_dout got=%0h exp=14", dout8); end checks++;
        clr8 = 1'b1;
        tick();
        clr8 = 1'b0;
        if (cnt8 !== 4'd0) begin errors++; $display("FAIL sat_clr_cnt got=%0d exp=0", cnt8); end checks++;
        if (dout8 !== 8'h14) begin errors++; $display("FAIL sat_clr_dout got=%0h exp=14", dout8); end checks++;
        if (vld8 !== 1'b0) begin errors++; $display("FAIL sat_clr_vld got=%0b exp=0", vld8); end checks++;
        $display("lane8 saturation cnt cleared dout=%0h", dout8);
    endtask

    task automatic test_clr_final();
        fire4 = 1'b1; din4 = 4'h7;
        tick();
        clr4 = 1'b1; din4 = 4'h8;
        tick();
        clr4 = 1'b0; fire4 = 1'b0;
        if (vld4 !== 1'b0) begin errors++; $display("FAIL clr_vld got=%0b exp=0", vld4); end checks++;
        if (dout4 !== 8'hA5) begin errors++; $display("FAIL clr_dout got=%0h exp=a5", dout4); end checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL clr_busy got=%0b exp=0", busy4); end checks++;
        if (cnt4 !== 12'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", cnt4); end checks++;
        if (err4 !== 1'b0) begin errors++; $display("FAIL clr_err got=%0b exp=0", err4); end checks++;
        fire4 = 1'b1; din4 = 4'h1;
        tick();
        din4 = 4'h2;
        tick();
        fire4 = 1'b0;
        if (dout4 !== 8'h12) begin errors++; $display("FAIL clr_realign got=%0h exp=12", dout4); end checks++;
        if (cnt4 !== 12'd1) begin errors++; $display("FAIL clr_recount got=%0d exp=1", cnt4); end checks++;
        tick();
        $display("lane4 clr on final beat dout=%0h", dout4);
    endtask

    task automatic test_rst_mid();
        fire4 = 1'b1; din4 = 4'h3;
        tick();
        fire4 = 1'b0;
        if (busy4 !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got=%0b exp=1", busy4); end checks++;
        #2 rst = 1'b1;
        #1;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0b exp=0", busy4); end checks++;
        if (dout4 !== 8'h00) begin errors++; $display("FAIL rmid_dout got=%0h exp=00", dout4); end checks++;
        if (cnt4 !== 12'd0) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", cnt4); end checks++;
        if (vld4 !== 1'b0) begin errors++; $display("FAIL rmid_vld got=%0b exp=0", vld4); end checks++;
        tick();
        rst = 1'b0;
        tick();
        if (err4 !== 1'b0) begin errors++; $display("FAIL rmid_err got=%0b exp=0", err4); end checks++;
        fire4 = 1'b1; din4 = 4'h1;
        tick();
        din4 = 4'h2;
        tick();
        fire4 = 1'b0;
        if (dout4 !== 8'h12) begin errors++; $display("FAIL rmid_realign got=%0h exp=12", dout4); end checks++;
        $display("lane4 mid-byte reset dout=%0h", dout4);
    endtask

    initial begin
        test_reset();
        test_lane4_basic();
        test_back_to_back();
        test_lane2_gaps();
        test_timeout();
        test_saturate();
        test_clr_final();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
